// File: rtl/io_pkg.sv
// Shared types and default constants for the UART receive path and idle-timeout interrupt generator.
// Build option: UART_RX_PARITY_EN adds an even-parity receive state.
package io_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 256;
  localparam int DEFAULT_LEN_W        = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_burst_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_burst_buffer.sv
// UART receiver feeding a byte FIFO, with burst packet length framing driven by burst_end.
// Build option: UART_RX_PARITY_EN selects 8E1 framing (even parity checked before the stop bit).
module uart_rx_burst_buffer
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int LEN_W        = DEFAULT_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_pin_in,
  input  logic             burst_end,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             frame_err,
  output logic             overflow
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic             sync1_q, sync2_q, rx_s;
  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             wr_q, wr_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             pkt_done_q, pkt_done_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [LEN_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0] cnt_inc, cnt_eff;
  logic             bit_tick;
  logic             fifo_full, fifo_empty, wr_accept;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wr_d        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    bit_tick    = (cnt_q == CW'(CLKS_PER_BIT - 1));
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_err_d = rx_s ^ even_parity(shift_q);
          state_d   = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = RX_RECOVER;
          end else begin
            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
            frame_err_d = par_err_q;
            wr_d        = ~par_err_q;
`else
            wr_d        = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_RECOVER: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign wr_accept = wr_q & (~fifo_full | (m_ready & ~fifo_empty));

  always_comb begin
    cnt_inc    = (pkt_cnt_q == {LEN_W{1'b1}}) ? pkt_cnt_q : pkt_cnt_q + 1'b1;
    cnt_eff    = wr_accept ? cnt_inc : pkt_cnt_q;
    overflow_d = overflow_q | (wr_q & ~wr_accept);
    pkt_done_d = 1'b0;
    pkt_len_d  = pkt_len_q;
    pkt_cnt_d  = cnt_eff;
    // A byte landing in the burst_end cycle still belongs to the closing packet.
    if (burst_end && (cnt_eff != '0)) begin
      pkt_done_d = 1'b1;
      pkt_len_d  = cnt_eff;
      pkt_cnt_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_len_q   <= '0;
      pkt_cnt_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx_pin_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      pkt_done_q  <= pkt_done_d;
      pkt_len_q   <= pkt_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_q),
    .wr_data (shift_q),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .empty   (fifo_empty)
  );

  assign m_valid   = ~fifo_empty;
  assign pkt_done  = pkt_done_q;
  assign pkt_len   = pkt_len_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_burst_buffer.sv
// Directed bench for uart_rx_burst_buffer with 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_burst_buffer;

  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_pin_in = 1'b1;
  logic        burst_end = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic        frame_err;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int fe_pulses = 0;
  int done_pulses = 0;

  always #5 clock = ~clock;

  uart_rx_burst_buffer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .LEN_W        (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_pin_in (rx_pin_in),
    .burst_end (burst_end),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always @(posedge clock) begin
    if (!reset) begin
      if (frame_err) fe_pulses <= fe_pulses + 1;
      if (pkt_done) done_pulses <= done_pulses + 1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one 8N1 frame; the line is left at the stop level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_pin_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_pin_in = d[i];
      wait_cycles(CPB);
    end
    rx_pin_in = stop;
    wait_cycles(CPB);
    wait_cycles(4);
    $display("sent frame %02h stop=%0b", d, stop);
  endtask

  task automatic pulse_burst();
    burst_end = 1'b1;
    @(negedge clock);
    burst_end = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got %b exp 0", pkt_done); end
    checks++; if (pkt_len !== 16'd0) begin errors++; $display("FAIL reset_pkt_len got %0d exp 0", pkt_len); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", m_data); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL single_done_early got %b exp 0", pkt_done); end
    pulse_burst();
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", pkt_done); end
    checks++; if (pkt_len !== 16'd1) begin errors++; $display("FAIL single_len got %0d exp 1", pkt_len); end
    @(negedge clock);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", pkt_done); end
    checks++; if (pkt_len !== 16'd1) begin errors++; $display("FAIL single_len_hold got %0d exp 1", pkt_len); end
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", m_valid); end
  endtask

  task automatic test_multi();
    logic [7:0] exp_bytes [3];
    exp_bytes = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b1);
    checks++; if (m_data !== 8'h01) begin errors++; $display("FAIL multi_head_stable got %h exp 01", m_data); end
    pulse_burst();
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL multi_done got %b exp 1", pkt_done); end
    checks++; if (pkt_len !== 16'd3) begin errors++; $display("FAIL multi_len got %0d exp 3", pkt_len); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== exp_bytes[i]) begin errors++; $display("FAIL multi_drain%0d got %b/%h exp 1/%h", i, m_valid, m_data, exp_bytes[i]); end
      $display("drained %02h", m_data);
      @(negedge clock);
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL multi_empty got %b exp 0", m_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
    send_frame(8'h14, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    pulse_burst();
    checks++; if (pkt_len !== 16'd4) begin errors++; $display("FAIL ovf_len got %0d exp 4", pkt_len); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got %b/%h exp 1/%h", i, m_valid, m_data, 8'h10 + 8'(i)); end
      @(negedge clock);
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", m_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_zero_burst();
    int d0;
    d0 = done_pulses;
    pulse_burst();
    wait_cycles(2);
    checks++; if (done_pulses !== d0) begin errors++; $display("FAIL zero_burst_done got %0d exp %0d", done_pulses, d0); end
    checks++; if (pkt_len !== 16'd4) begin errors++; $display("FAIL zero_burst_len got %0d exp 4", pkt_len); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = fe_pulses;
    rx_pin_in = 1'b0;
    wait_cycles(4);
    rx_pin_in = 1'b1;
    wait_cycles(20);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_byte got %b exp 0", m_valid); end
    checks++; if (fe_pulses !== f0) begin errors++; $display("FAIL glitch_no_ferr got %0d exp %0d", fe_pulses, f0); end
    send_frame(8'h5A, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin errors++; $display("FAIL glitch_next got %b/%h exp 1/5a", m_valid, m_data); end
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = fe_pulses;
    send_frame(8'h55, 1'b0);
    wait_cycles(20);
    checks++; if (fe_pulses !== f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", fe_pulses, f0 + 1); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_byte got %b exp 0", m_valid); end
    rx_pin_in = 1'b1;
    wait_cycles(6);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ferr_after_high got %b exp 0", m_valid); end
    send_frame(8'h66, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h66) begin errors++; $display("FAIL ferr_recover got %b/%h exp 1/66", m_valid, m_data); end
  endtask

  task automatic test_reset_mid_frame();
    rx_pin_in = 1'b0;
    wait_cycles(CPB);
    rx_pin_in = 1'b1;
    wait_cycles(40);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", m_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got %b exp 0", overflow); end
    checks++; if (pkt_len !== 16'd0) begin errors++; $display("FAIL rst_mid_len got %0d exp 0", pkt_len); end
    checks++; if (pkt_done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses got %b/%b exp 0/0", pkt_done, frame_err); end
    wait_cycles(20);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_byte got %b exp 0", m_valid); end
    send_frame(8'h3C, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h3C) begin errors++; $display("FAIL rst_mid_next got %b/%h exp 1/3c", m_valid, m_data); end
    pulse_burst();
    checks++; if (pkt_done !== 1'b1 || pkt_len !== 16'd1) begin errors++; $display("FAIL rst_mid_pkt got %b/%0d exp 1/1", pkt_done, pkt_len); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_zero_burst();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
